cv32e40p_x_result_tx: RTL and testbench



---
 rtl/cv32e40p_pkg.sv | 11 +
 rtl/cv32e40p_x_result_fifo.sv | 90 +++++++++
 rtl/cv32e40p_x_result_tx.sv | 73 +++++++
 tb/tb_cv32e40p_x_result_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the X-Interface coprocessor result path.
package cv32e40p_pkg;

  localparam int unsigned X_RES_FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Generic synchronous FIFO of x_result_t with flush, occupancy count and a
// flat view of all entries plus their validity.
module cv32e40p_x_result_fifo
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = X_RES_FIFO_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  x_result_t                data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output x_result_t                head_o,
  output x_result_t [DEPTH-1:0]    entries_o,
  output logic      [DEPTH-1:0]    valid_o,
  output logic      [PTR_W:0]      count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  x_result_t            mem_q [DEPTH];
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + PTR_ONE;
      if (pop_en)  rptr_d = rptr_q + PTR_ONE;
      if (push_en && !pop_en)      count_d = count_q + CNT_ONE;
      else if (pop_en && !push_en) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    off       = '0;
    entries_o = '0;
    valid_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rptr_q;
      entries_o[i] = mem_q[i];
      valid_o[i]   = ({1'b0, off} < count_q);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push_i |-> !full_o);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/cv32e40p_x_result_tx.sv
// X-Interface result transmitter: filters non-writeback results, buffers the
// rest and exposes a pending-destination bitmap for hazard scoreboarding.
module cv32e40p_x_result_tx
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH = X_RES_FIFO_DEPTH_DEFAULT,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic             res_we_i,
  input  logic [4:0]       res_rd_i,
  input  logic [31:0]      res_data_i,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rd_o,
  output logic [31:0]      x_data_o,
  input  logic             flush_i,
  output logic [31:0]      pending_rd_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  x_result_t             push_data;
  x_result_t             head;
  x_result_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] valid;
  logic                  accept, push, pop;

  // Ready depends only on occupancy so x_rready_i never reaches res_ready_o.
  assign res_ready_o = ~full_o;
  assign accept      = res_valid_i & res_ready_o;
  assign push        = accept & res_we_i & (res_rd_i != 5'd0) & ~flush_i;
  assign pop         = x_rvalid_o & x_rready_i;
  assign push_data   = '{rd: res_rd_i, data: res_data_i};

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .data_i    (push_data),
    .pop_i     (pop),
    .flush_i   (flush_i),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (valid),
    .count_o   (count_o),
    .empty_o   (empty_o),
    .full_o    (full_o)
  );

  assign x_rvalid_o = ~empty_o;
  assign x_rd_o     = empty_o ? 5'd0  : head.rd;
  assign x_data_o   = empty_o ? 32'd0 : head.data;

  always_comb begin
    pending_rd_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending_rd_o[entries[i].rd] = 1'b1;
    end
    pending_rd_o[0] = 1'b0;
  end

  a_rd_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
    x_rvalid_o |-> (x_rd_o != 5'd0));

endmodule

// File: tb/tb_cv32e40p_x_result_tx.sv
// Directed scoreboard bench for cv32e40p_x_result_tx (DEPTH = 4).
module tb_cv32e40p_x_result_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resValid, resWe, xReady, flush;
  logic [4:0]  resRd;
  logic [31:0] resData;
  logic        resReady, xValid, emptyO, fullO;
  logic [4:0]  xRd;
  logic [31:0] xData, pendingRd;
  logic [2:0]  countO;

  logic [36:0] scoreboard[$];
  int          numChecks = 0;
  int          numFails  = 0;

  always #5 clk = ~clk;

  cv32e40p_x_result_tx #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid_i  (resValid),
    .res_ready_o  (resReady),
    .res_we_i     (resWe),
    .res_rd_i     (resRd),
    .res_data_i   (resData),
    .x_rvalid_o   (xValid),
    .x_rready_i   (xReady),
    .x_rd_o       (xRd),
    .x_data_o     (xData),
    .flush_i      (flush),
    .pending_rd_o (pendingRd),
    .count_o      (countO),
    .empty_o      (emptyO),
    .full_o       (fullO)
  );

  // Monitor: every handshake seen mid-cycle must match the oldest expected result.
  always @(negedge clk) begin
    logic [36:0] expItem;
    if (rst_n && xValid && xReady) begin
      numChecks++;
      if (scoreboard.size() == 0) begin
        numFails++;
        $display("[TB] FAIL unexpected_pop: got rd=%0d data=%h, required no output", xRd, xData);
      end else begin
        expItem = scoreboard.pop_front();
        if ({xRd, xData} !== expItem) begin
          numFails++;
          $display("[TB] FAIL pop_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   xRd, xData, expItem[36:32], expItem[31:0]);
        end
      end
    end
    if (flush) scoreboard.delete();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic expectPush);
    resValid = 1'b1;
    resWe    = we;
    resRd    = rd;
    resData  = data;
    if (expectPush) scoreboard.push_back({rd, data});
    tick();
    resValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; resValid = 0; resWe = 0; resRd = 0; resData = 0; xReady = 0; flush = 0;
    #3;
    checkOutput("reset_count",   32'(countO),   32'd0);
    checkOutput("reset_rvalid",  32'(xValid),   32'd0);
    checkOutput("reset_pending", pendingRd,     32'd0);
    checkOutput("reset_empty",   32'(emptyO),   32'd1);
    checkOutput("reset_full",    32'(fullO),    32'd0);
    checkOutput("reset_ready",   32'(resReady), 32'd1);
    checkOutput("reset_rd",      32'(xRd),      32'd0);
    checkOutput("reset_data",    xData,         32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single result");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("single_rvalid",  32'(xValid), 32'd1);
      checkOutput("single_rd",      32'(xRd),    32'd5);
      checkOutput("single_data",    xData,       32'hDEADBEEF);
      checkOutput("single_pending", pendingRd,   32'h20);
      tick();
    end
    xReady = 1'b1; tick(); xReady = 1'b0;
    checkOutput("single_rvalid_after", 32'(xValid), 32'd0);
    checkOutput("single_pending_after", pendingRd,  32'd0);

    $display("[TB] filtering");
    checkOutput("filter_ready", 32'(resReady), 32'd1);
    applyStimulus(1'b0, 5'd7, 32'h7777, 1'b0);
    checkOutput("filter_we_count",  32'(countO), 32'd0);
    applyStimulus(1'b1, 5'd0, 32'h0000, 1'b0);
    checkOutput("filter_rd0_count", 32'(countO), 32'd0);
    checkOutput("filter_rvalid",    32'(xValid), 32'd0);

    $display("[TB] fill and backpressure");
    for (int r = 1; r <= 4; r++) applyStimulus(1'b1, 5'(r), 32'h100 + r, 1'b1);
    checkOutput("fill_full",    32'(fullO),    32'd1);
    checkOutput("fill_ready",   32'(resReady), 32'd0);
    checkOutput("fill_pending", pendingRd,     32'h1E);
    resValid = 1'b1; resWe = 1'b1; resRd = 5'd6; resData = 32'h106;
    tick();
    checkOutput("fill_blocked_count", 32'(countO), 32'd4);
    xReady = 1'b1; tick(); xReady = 1'b0;
    checkOutput("fill_pop_count", 32'(countO),   32'd3);
    checkOutput("fill_ready_back", 32'(resReady), 32'd1);
    scoreboard.push_back({5'd6, 32'h106});
    tick();
    resValid = 1'b0;
    checkOutput("fill_refill_count", 32'(countO), 32'd4);
    checkOutput("fill_pending2",     pendingRd,   32'h5C);
    xReady = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    xReady = 1'b0;
    checkOutput("fill_drained", 32'(emptyO), 32'd1);

    $display("[TB] wrap-around");
    xReady = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      applyStimulus(1'b1, 5'(r), 32'h200 + r, 1'b1);
      checkOutput("wrap_count", 32'(countO), 32'd1);
    end
    tick();
    xReady = 1'b0;
    checkOutput("wrap_empty", 32'(countO), 32'd0);

    $display("[TB] duplicate rd");
    applyStimulus(1'b1, 5'd3, 32'hAAAA0003, 1'b1);
    applyStimulus(1'b1, 5'd3, 32'hBBBB0003, 1'b1);
    checkOutput("dup_pending2", pendingRd, 32'h8);
    xReady = 1'b1; tick(); xReady = 1'b0;
    checkOutput("dup_pending1", pendingRd, 32'h8);
    xReady = 1'b1; tick(); xReady = 1'b0;
    checkOutput("dup_pending0", pendingRd, 32'h0);

    $display("[TB] flush");
    for (int r = 10; r <= 12; r++) applyStimulus(1'b1, 5'(r), 32'h300 + r, 1'b1);
    checkOutput("flush_pre_count", 32'(countO), 32'd3);
    flush = 1'b1;
    applyStimulus(1'b1, 5'd13, 32'h313, 1'b0);
    flush = 1'b0;
    checkOutput("flush_count",   32'(countO), 32'd0);
    checkOutput("flush_rvalid",  32'(xValid), 32'd0);
    checkOutput("flush_pending", pendingRd,   32'd0);
    applyStimulus(1'b1, 5'd14, 32'h314, 1'b1);
    flush = 1'b1; xReady = 1'b1; tick(); flush = 1'b0; xReady = 1'b0;
    checkOutput("flush_pop_count", 32'(countO), 32'd0);

    $display("[TB] async reset");
    applyStimulus(1'b1, 5'd20, 32'h420, 1'b1);
    applyStimulus(1'b1, 5'd21, 32'h421, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    scoreboard.delete();
    checkOutput("areset_count",   32'(countO),   32'd0);
    checkOutput("areset_rvalid",  32'(xValid),   32'd0);
    checkOutput("areset_pending", pendingRd,     32'd0);
    checkOutput("areset_ready",   32'(resReady), 32'd1);
    checkOutput("areset_rd",      32'(xRd),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 5'd9, 32'h909, 1'b1);
    checkOutput("post_reset_rd", 32'(xRd), 32'd9);
    xReady = 1'b1; tick(); xReady = 1'b0;

    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
